// File: rtl/abft_matrix_checker.sv
// ABFT checksum checker: N row beats plus one column beat per frame, reports row/column mismatches.
// Optional macro ABFT_ERRCNT_EN enables the saturating count of frames with a mismatch.
module abft_matrix_checker #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  localparam int unsigned CW = DW + $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] row_data,
  input  logic [CW-1:0]   row_chk,
  input  logic [N*CW-1:0] col_chk,
  output logic            done,
  output logic [N-1:0]    err_row_mask,
  output logic [N-1:0]    err_col_mask,
  output logic            single_fault,
  output logic            error,
  output logic [15:0]     err_cnt
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_ROW, S_COL, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   row_idx;
  logic [CW-1:0]   col_acc [N];
  logic [N-1:0]    shd_row;
  logic [CW-1:0]   row_sum_c;
  logic            row_mis_c;
  logic [N-1:0]    col_mis_c;
  logic            last_row_c;
  logic            accept_c;
  logic            frame_bad_c;

  // Next state plus per-beat checksum compares.
  always_comb begin
    state_nxt   = state;
    row_sum_c   = '0;
    col_mis_c   = '0;
    accept_c    = in_valid && (state != S_DONE) && !clr;
    last_row_c  = (row_idx == IW'(N - 1));
    for (int j = 0; j < N; j++) begin
      row_sum_c    = row_sum_c + CW'(row_data[j*DW +: DW]);
      col_mis_c[j] = (col_acc[j] != col_chk[j*CW +: CW]);
    end
    row_mis_c   = (row_sum_c != row_chk);
    frame_bad_c = (|shd_row) || (|col_mis_c);
    case (state)
      S_ROW:   if (accept_c && last_row_c) state_nxt = S_COL;
      S_COL:   if (accept_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_ROW;
      default: state_nxt = S_ROW;
    endcase
    if (clr) state_nxt = S_ROW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_ROW;
      in_ready <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != S_DONE);
      done     <= (state_nxt == S_DONE);
    end
  end

  // Accumulation into shadow state; results published only when the column beat lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx      <= '0;
      shd_row      <= '0;
      err_row_mask <= '0;
      err_col_mask <= '0;
      single_fault <= 1'b0;
      error        <= 1'b0;
      for (int j = 0; j < N; j++) col_acc[j] <= '0;
    end else if (clr) begin
      row_idx      <= '0;
      shd_row      <= '0;
      err_row_mask <= '0;
      err_col_mask <= '0;
      single_fault <= 1'b0;
      error        <= 1'b0;
      for (int j = 0; j < N; j++) col_acc[j] <= '0;
    end else begin
      case (state)
        S_ROW: begin
          if (accept_c) begin
            shd_row[row_idx] <= row_mis_c;
            for (int j = 0; j < N; j++) col_acc[j] <= col_acc[j] + CW'(row_data[j*DW +: DW]);
            row_idx <= last_row_c ? '0 : row_idx + IW'(1);
          end
        end
        S_COL: begin
          if (accept_c) begin
            err_row_mask <= shd_row;
            err_col_mask <= col_mis_c;
            single_fault <= $onehot(shd_row) && $onehot(col_mis_c);
            if (frame_bad_c) error <= 1'b1;
          end
        end
        S_DONE: begin
          shd_row <= '0;
          for (int j = 0; j < N; j++) col_acc[j] <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef ABFT_ERRCNT_EN
  // Saturating count of frames that carried any mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if ((state == S_COL) && accept_c && frame_bad_c && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_abft_matrix_checker.sv
// Randomized self-checking bench for abft_matrix_checker against a matrix-level model.
module tb_abft_matrix_checker;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = DW + $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] row_data = '0;
  logic [CW-1:0]   row_chk = '0;
  logic [N*CW-1:0] col_chk = '0;
  logic            done;
  logic [N-1:0]    err_row_mask, err_col_mask;
  logic            single_fault, error;
  logic [15:0]     err_cnt;

  abft_matrix_checker #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .row_data(row_data), .row_chk(row_chk), .col_chk(col_chk), .done(done),
    .err_row_mask(err_row_mask), .err_col_mask(err_col_mask),
    .single_fault(single_fault), .error(error), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncalls = 0;

  // Frame under construction by the stimulus side.
  int rows [N][N];
  int rchk [N];
  int cchk [N];

  // Model state: accepted matrix and expected published results.
  int           m_rows [N][N];
  int           m_rchk [N];
  int           beats = 0;
  bit           exp_done = 1'b0;
  logic [N-1:0] exp_rm = '0, exp_cm = '0;
  bit           exp_sf = 1'b0, exp_err = 1'b0;
  int           exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    beats = 0; exp_done = 1'b0; exp_rm = '0; exp_cm = '0;
    exp_sf = 1'b0; exp_err = 1'b0; exp_cnt = 0;
  endtask

  // Whole-frame evaluation: plain sums over the stored matrix.
  task automatic model_frame();
    int s;
    exp_rm = '0; exp_cm = '0;
    for (int k = 0; k < N; k++) begin
      s = 0;
      for (int j = 0; j < N; j++) s += m_rows[k][j];
      exp_rm[k] = (s != m_rchk[k]);
    end
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += m_rows[k][j];
      exp_cm[j] = (s != int'(col_chk[j*CW +: CW]));
    end
    exp_sf = ($countones(exp_rm) == 1) && ($countones(exp_cm) == 1);
    if ((exp_rm != '0) || (exp_cm != '0)) begin
      exp_err = 1'b1;
`ifdef ABFT_ERRCNT_EN
      if (exp_cnt < 65535) exp_cnt++;
`endif
    end
  endtask

  task automatic model_step(input bit v, input bit c);
    if (c) model_reset();
    else if (exp_done) exp_done = 1'b0;
    else if (v) begin
      if (beats < N) begin
        for (int j = 0; j < N; j++) m_rows[beats][j] = int'(row_data[j*DW +: DW]);
        m_rchk[beats] = int'(row_chk);
        beats++;
      end else begin
        model_frame();
        exp_done = 1'b1;
        beats = 0;
      end
    end
  endtask

  task automatic cycle(input bit v, input bit c);
    in_valid = v; clr = c;
    @(posedge clk); #1;
    ncalls++;
    model_step(v, c);
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int j = 0; j < N; j++) begin
      row_data[j*DW +: DW] = DW'($urandom);
      col_chk[j*CW +: CW]  = CW'($urandom);
    end
    row_chk = CW'($urandom);
  endtask

  task automatic put_row(input int k);
    for (int j = 0; j < N; j++) row_data[j*DW +: DW] = DW'(rows[k][j]);
    row_chk = CW'(rchk[k]);
  endtask

  task automatic put_col();
    for (int j = 0; j < N; j++) col_chk[j*CW +: CW] = CW'(cchk[j]);
  endtask

  task automatic fill_chks();
    for (int k = 0; k < N; k++) begin
      rchk[k] = 0;
      for (int j = 0; j < N; j++) rchk[k] += rows[k][j];
    end
    for (int j = 0; j < N; j++) begin
      cchk[j] = 0;
      for (int k = 0; k < N; k++) cchk[j] += rows[k][j];
    end
  endtask

  task automatic build_rand();
    int mode, k, j;
    bit full;
    mode = $urandom_range(0, 4);
    full = ($urandom_range(0, 9) == 0);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) rows[a][b] = full ? 255 : $urandom_range(0, 255);
    fill_chks();
    k = $urandom_range(0, N-1); j = $urandom_range(0, N-1);
    case (mode)
      1: rows[k][j] = (rows[k][j] + $urandom_range(1, 255)) % 256;
      2: rchk[k] = (rchk[k] + $urandom_range(1, 1023)) % 1024;
      3: cchk[j] = (cchk[j] + $urandom_range(1, 1023)) % 1024;
      4: begin
        rows[k][j] = (rows[k][j] + $urandom_range(1, 255)) % 256;
        rows[$urandom_range(0, N-1)][$urandom_range(0, N-1)] = $urandom_range(0, 255);
      end
      default: ;
    endcase
  endtask

  // Drive beats 0..n-1 of the frame (n = N+1 is a full frame ending with the column beat).
  task automatic send_beats(input int n, input int gapmax, input bit toggle);
    int gaps;
    for (int b = 0; b < n; b++) begin
      gaps = toggle ? int'(b > 0) : $urandom_range(0, gapmax);
      repeat (gaps) begin rand_inputs(); cycle(1'b0, 1'b0); end
      rand_inputs();
      if (b < N) put_row(b); else put_col();
      cycle(1'b1, 1'b0);
    end
  endtask

  task automatic done_cycle();
    rand_inputs();
    cycle(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic directed_base();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) rows[k][j] = (k + 1) * (j + 1);
    fill_chks();
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(!exp_done));
    chk("done", 64'(done), 64'(exp_done));
    chk("err_row_mask", 64'(err_row_mask), 64'(exp_rm));
    chk("err_col_mask", 64'(err_col_mask), 64'(exp_cm));
    chk("single_fault", 64'(single_fault), 64'(exp_sf));
    chk("error", 64'(error), 64'(exp_err));
    chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
  end

  initial begin
    int cnt1, start, ncyc;
`ifdef ABFT_ERRCNT_EN
    cnt1 = 1;
`else
    cnt1 = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Clean frame, back to back.
    directed_base();
    send_beats(N + 1, 0, 1'b0);
    done_cycle();
    chk("lit_clean_rm", 64'(err_row_mask), 64'h0);
    chk("lit_clean_cm", 64'(err_col_mask), 64'h0);
    chk("lit_clean_err", 64'(error), 64'h0);

    // Single corrupted element: locatable fault.
    directed_base();
    rows[2][1] = 7;
    send_beats(N + 1, 0, 1'b0);
    chk("model_rm", 64'(exp_rm), 64'h4);
    chk("model_cm", 64'(exp_cm), 64'h2);
    done_cycle();
    chk("lit_sf_rm", 64'(err_row_mask), 64'h4);
    chk("lit_sf_cm", 64'(err_col_mask), 64'h2);
    chk("lit_sf", 64'(single_fault), 64'h1);
    chk("lit_sf_err", 64'(error), 64'h1);
    chk("lit_sf_cnt", 64'(err_cnt), 64'(cnt1));

    // Alternating valid: 10 cycles to done.
    directed_base();
    start = ncalls;
    send_beats(N + 1, 0, 1'b1);
    @(negedge clk);
    ncyc = done ? (ncalls - start + 1) : 0;
    chk("toggle_latency", 64'(ncyc), 64'd10);
    done_cycle();
    chk("lit_toggle_rm", 64'(err_row_mask), 64'h0);

    // Width boundary: all elements 255.
    for (int k = 0; k < N; k++) for (int j = 0; j < N; j++) rows[k][j] = 255;
    fill_chks();
    chk("model_chk1020", 64'(rchk[0]), 64'd1020);
    send_beats(N + 1, 1, 1'b0);
    done_cycle();
    chk("lit_full_rm", 64'(err_row_mask), 64'h0);
    chk("lit_full_cm", 64'(err_col_mask), 64'h0);
    rchk[1] = 1019;
    send_beats(N + 1, 1, 1'b0);
    done_cycle();
    chk("lit_1019_rm", 64'(err_row_mask), 64'h2);
    chk("lit_1019_sf", 64'(single_fault), 64'h0);

    // Soft clear with a beat offered after two rows.
    directed_base();
    send_beats(2, 0, 1'b0);
    rand_inputs();
    cycle(1'b1, 1'b1);
    chk("lit_clr_err", 64'(error), 64'h0);
    chk("lit_clr_cnt", 64'(err_cnt), 64'h0);
    send_beats(N + 1, 0, 1'b0);
    done_cycle();

    // Async reset mid-frame, then a faulty frame.
    send_beats(3, 0, 1'b0);
    cycle(1'b0, 1'b0);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("lit_rst_done", 64'(done), 64'h0);
    chk("lit_rst_err", 64'(error), 64'h0);
    chk("lit_rst_rm", 64'(err_row_mask), 64'h0);
    #2 rst = 1'b0;
    directed_base();
    rows[2][1] = 7;
    send_beats(N + 1, 0, 1'b0);
    done_cycle();
    chk("lit_postrst_cnt", 64'(err_cnt), 64'(cnt1));

    // Randomized frames with gaps, clears and resets.
    for (int f = 0; f < 300; f++) begin
      build_rand();
      case ($urandom_range(0, 19))
        0: begin
          send_beats($urandom_range(0, N), 2, 1'b0);
          rand_inputs();
          cycle(1'($urandom_range(0, 1)), 1'b1);
        end
        1: begin
          send_beats($urandom_range(0, N), 2, 1'b0);
          cycle(1'b0, 1'b0);
          #1 rst = 1'b1;
          model_reset();
          @(negedge clk);
          #2 rst = 1'b0;
        end
        default: begin
          send_beats(N + 1, 3, 1'b0);
          done_cycle();
        end
      endcase
    end

    repeat (3) cycle(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
